// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch (IF) and data (DM) requesters.
// Registers the granted request onto the port, counts out LAT cycles and returns data with a done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = $clog2(LAT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t            state, state_nx;
  owner_t            owner, owner_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              mem_en_nx, mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;
  logic [DATA_W-1:0] if_rdata_nx, dm_rdata_nx;
  logic              if_done_nx, dm_done_nx;
  logic              grant_dm, grant_if;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      cnt       <= cnt_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_rdata  <= if_rdata_nx;
      dm_rdata  <= dm_rdata_nx;
      if_done   <= if_done_nx;
      dm_done   <= dm_done_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_nx     = state;
    owner_nx     = owner;
    cnt_nx       = cnt;
    mem_en_nx    = mem_en;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    dm_rdata_nx  = dm_rdata;
    if_done_nx   = 1'b0;
    dm_done_nx   = 1'b0;
    grant_dm     = 1'b0;
    grant_if     = 1'b0;

    case (state)
      IDLE, RESP: begin
        state_nx = IDLE;
        // DM wins unless it was just served and IF is waiting, which forces alternation.
        grant_dm = dm_req && !(state == RESP && owner == OWN_DM && if_req);
        grant_if = !grant_dm && if_req;
        if (grant_dm) begin
          state_nx     = BUSY;
          owner_nx     = OWN_DM;
          cnt_nx       = CNT_W'(LAT - 1);
          mem_en_nx    = 1'b1;
          mem_we_nx    = dm_we;
          mem_addr_nx  = dm_addr;
          mem_wdata_nx = dm_wdata;
        end else if (grant_if) begin
          state_nx     = BUSY;
          owner_nx     = OWN_IF;
          cnt_nx       = CNT_W'(LAT - 1);
          mem_en_nx    = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = if_addr;
          mem_wdata_nx = '0;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          state_nx  = RESP;
          mem_en_nx = 1'b0;
          mem_we_nx = 1'b0;
          if (owner == OWN_DM) begin
            dm_done_nx = 1'b1;
            if (!mem_we) dm_rdata_nx = mem_rdata;
          end else begin
            if_done_nx  = 1'b1;
            if_rdata_nx = mem_rdata;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter at LAT=1,2,3 against a transaction-timing reference model.
// Each latency gets its own DUT, requester agents, memory array and model; counters are shared.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int blocks_done = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_lat
    localparam int L = k + 1;

    logic        rst, if_req, dm_req, dm_we;
    logic        if_done, dm_done, mem_en, mem_we, stall;
    logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [16];

    assign mem_rdata = mem[mem_addr[5:2]];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(L)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall)
    );

    initial begin : run
      // Model: the access in flight is described by its grant cycle g; port busy g+1..g+L, done at g+L+1.
      bit          have, own_dm, t_we, e_en, e_we, e_ifd, e_dmd, rst_now, in_resp, pick_dm, pick_if;
      int          g;
      logic [31:0] t_addr, t_wdata, t_rdata, e_addr, e_wdata, e_if_rd, e_dm_rd;

      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("lat%0d reset mem_en", L),    32'(mem_en),    32'd0);
      check($sformatf("lat%0d reset mem_we", L),    32'(mem_we),    32'd0);
      check($sformatf("lat%0d reset mem_addr", L),  mem_addr,       32'd0);
      check($sformatf("lat%0d reset mem_wdata", L), mem_wdata,      32'd0);
      check($sformatf("lat%0d reset if_rdata", L),  if_rdata,       32'd0);
      check($sformatf("lat%0d reset dm_rdata", L),  dm_rdata,       32'd0);
      check($sformatf("lat%0d reset if_done", L),   32'(if_done),   32'd0);
      check($sformatf("lat%0d reset dm_done", L),   32'(dm_done),   32'd0);
      check($sformatf("lat%0d reset stall", L),     32'(stall),     32'd0);
      rst = 1'b0;

      have = 1'b0; own_dm = 1'b0; t_we = 1'b0; g = 0;
      t_addr = '0; t_wdata = '0; t_rdata = '0;
      e_addr = '0; e_wdata = '0; e_if_rd = '0; e_dm_rd = '0;

      for (int c = 0; c < 400; c++) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        e_en  = have && c >= g + 1 && c <= g + L;
        e_we  = e_en && t_we;
        e_ifd = have && c == g + L + 1 && !own_dm;
        e_dmd = have && c == g + L + 1 && own_dm;
        if (have && c == g + 1) begin
          e_addr  = t_addr;
          e_wdata = t_wdata;
        end
        if (e_ifd) e_if_rd = t_rdata;
        if (e_dmd && !t_we) e_dm_rd = t_rdata;
        if (e_dmd && t_we) mem[t_addr[5:2]] = t_wdata;

        check($sformatf("lat%0d c%0d mem_en", L, c),    32'(mem_en),  32'(e_en));
        check($sformatf("lat%0d c%0d mem_we", L, c),    32'(mem_we),  32'(e_we));
        check($sformatf("lat%0d c%0d mem_addr", L, c),  mem_addr,     e_addr);
        check($sformatf("lat%0d c%0d mem_wdata", L, c), mem_wdata,    e_wdata);
        check($sformatf("lat%0d c%0d if_done", L, c),   32'(if_done), 32'(e_ifd));
        check($sformatf("lat%0d c%0d dm_done", L, c),   32'(dm_done), 32'(e_dmd));
        check($sformatf("lat%0d c%0d if_rdata", L, c),  if_rdata,     e_if_rd);
        check($sformatf("lat%0d c%0d dm_rdata", L, c),  dm_rdata,     e_dm_rd);

        // Agents hold a request until its done, then either drop it or present a fresh one.
        rst_now = (c % 53) == 30;
        if (rst_now) begin
          rst = 1'b1;
          if_req = 1'b0;
          dm_req = 1'b0;
        end else begin
          if (!if_req || e_ifd) begin
            if_req  = $urandom_range(0, 3) != 0;
            if_addr = 32'($urandom_range(0, 15)) << 2;
          end
          if (!dm_req || e_dmd) begin
            dm_req   = $urandom_range(0, 2) != 0;
            dm_we    = $urandom_range(0, 2) == 0;
            dm_addr  = 32'($urandom_range(0, 15)) << 2;
            dm_wdata = $urandom;
          end
        end

        if (rst_now) begin
          have = 1'b0;
          e_addr = '0; e_wdata = '0; e_if_rd = '0; e_dm_rd = '0;
        end else if (!have || c >= g + L + 1) begin
          in_resp = have && c == g + L + 1;
          pick_dm = dm_req && !(in_resp && own_dm && if_req);
          pick_if = !pick_dm && if_req;
          have = pick_dm || pick_if;
          if (have) begin
            g       = c;
            own_dm  = pick_dm;
            t_addr  = pick_dm ? dm_addr : if_addr;
            t_we    = pick_dm && dm_we;
            t_wdata = pick_dm ? dm_wdata : 32'd0;
            t_rdata = mem[t_addr[5:2]];
          end
        end

        #1;
        check($sformatf("lat%0d c%0d stall", L, c), 32'(stall),
              32'((if_req && !e_ifd) || (dm_req && !e_dmd)));
      end
      blocks_done++;
    end
  end

  initial begin
    for (int i = 0; i < 5000 && blocks_done < 3; i++) @(posedge clk);
    check("all latency blocks finished", 32'(blocks_done), 32'd3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
